// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM type and preload table for data_mem_seq.
package data_mem_pkg;

    typedef enum logic {INIT, READY} data_mem_state_t;

    localparam int PRELOAD_N = 4;

    // Entry 0 is the first preload write after the clear sweep.
    localparam logic [PRELOAD_N-1:0][31:0] PRELOAD_ADDR =
        {32'd15, 32'd2, 32'd1, 32'd0};
    localparam logic [PRELOAD_N-1:0][31:0] PRELOAD_DATA =
        {32'd15, 32'd3, 32'd2, 32'd7};

endpackage

// File: rtl/data_mem_init_seq.sv
// data_mem_init_seq: clear sweep over DEPTH words followed by the preload writes.
// idx saturates on its last step; init_done_o marks that final write cycle.
module data_mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int W     = 8,
    parameter int A     = 8,
    parameter int DEPTH = 256
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic         init_we_o,
    output logic [A-1:0] init_addr_o,
    output logic [W-1:0] init_data_o,
    output logic         init_done_o
);

    localparam int IW = $clog2(DEPTH + PRELOAD_N);
    localparam logic [IW-1:0] DEP  = IW'(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH + PRELOAD_N - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    pre;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (en_i && idx_q != LAST) begin
            idx_d = idx_q + IW'(1);
        end
    end

    always_comb begin
        pre         = 2'(idx_q - DEP);
        init_we_o   = 1'b0;
        init_addr_o = '0;
        init_data_o = '0;
        if (idx_q < DEP) begin
            init_we_o   = en_i;
            init_addr_o = A'(idx_q);
        end else begin
            // Out-of-range preload slots still burn their cycle.
            init_we_o   = en_i && (PRELOAD_ADDR[pre] < 32'(DEPTH));
            init_addr_o = A'(PRELOAD_ADDR[pre]);
            init_data_o = W'(PRELOAD_DATA[pre]);
        end
    end

    assign init_done_o = (idx_q == LAST);

endmodule

// File: rtl/data_mem_seq.sv
// data_mem_seq: valid/ready data memory with 1-cycle registered read.
// Optional post-reset clear/preload sweep enabled by DATA_MEM_INIT_EN.
module data_mem_seq
    import data_mem_pkg::*;
#(
    parameter int W     = 8,
    parameter int A     = 8,
    parameter int DEPTH = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic [A-1:0] ReqAddr,
    input  logic [W-1:0] ReqData,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic         AddrErr,
    output logic         Busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_MEM_INIT_EN
    localparam data_mem_state_t RST_STATE = INIT;
`else
    localparam data_mem_state_t RST_STATE = READY;
`endif

    data_mem_state_t state_q, state_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            addr_err_q, addr_err_d;

    logic [W-1:0] mem_q [DEPTH];

    logic         acc, in_range;
    logic         init_en, init_we, init_done;
    logic [A-1:0] init_addr;
    logic [W-1:0] init_data;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;

    assign init_en  = (state_q == INIT) && !Reset;
    assign acc      = ReqValid && ready_q;
    assign in_range = 32'(ReqAddr) < 32'(DEPTH);

    data_mem_init_seq #(
        .W     (W),
        .A     (A),
        .DEPTH (DEPTH)
    ) u_init (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .en_i        (init_en),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_data_o (init_data),
        .init_done_o (init_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= RST_STATE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:  if (init_done) state_d = READY;
            READY: state_d = READY;
        endcase
        ready_d     = (state_d == READY);
        rsp_valid_d = acc && !ReqWrite;
        addr_err_d  = acc && !in_range;
        rsp_data_d  = rsp_data_q;
        if (acc && !ReqWrite) begin
            rsp_data_d = in_range ? mem_q[ReqAddr[AW-1:0]] : '0;
        end
    end

    // Single write port: the sweep owns it while in INIT.
    always_comb begin
        wr_en   = acc && ReqWrite && in_range;
        wr_addr = ReqAddr;
        wr_data = ReqData;
        if (state_q == INIT) begin
            wr_en   = init_we;
            wr_addr = init_addr;
            wr_data = init_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign AddrErr  = addr_err_q;
`ifdef DATA_MEM_INIT_EN
    assign Busy = (state_q == INIT);
`else
    assign Busy = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_seq.sv
// tb_data_mem_seq: directed bench for data_mem_seq (DEPTH=256 and DEPTH=200).
// Expectations follow DATA_MEM_INIT_EN when the bench is built with it.
module tb_data_mem_seq;

`ifdef DATA_MEM_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int LAT0 = INIT_EN ? 260 : 1;
    localparam int LAT1 = INIT_EN ? 204 : 1;
    localparam logic BUSY_RST = INIT_EN;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst0, V0, Wr0, Rdy0, RV0, AE0, By0;
    logic [7:0] Ad0, Dt0, RD0;
    logic       Rst1, V1, Wr1, Rdy1, RV1, AE1, By1;
    logic [7:0] Ad1, Dt1, RD1;

    int passed = 0;
    int total  = 0;

    data_mem_seq #(.W(8), .A(8), .DEPTH(256)) dut0 (
        .Clk(Clk), .Reset(Rst0), .ReqValid(V0), .ReqReady(Rdy0),
        .ReqWrite(Wr0), .ReqAddr(Ad0), .ReqData(Dt0),
        .RspValid(RV0), .RspData(RD0), .AddrErr(AE0), .Busy(By0)
    );

    data_mem_seq #(.W(8), .A(8), .DEPTH(200)) dut1 (
        .Clk(Clk), .Reset(Rst1), .ReqValid(V1), .ReqReady(Rdy1),
        .ReqWrite(Wr1), .ReqAddr(Ad1), .ReqData(Dt1),
        .RspValid(RV1), .RspData(RD1), .AddrErr(AE1), .Busy(By1)
    );

    task automatic drv0(input logic v, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        V0 = v; Wr0 = w; Ad0 = a; Dt0 = d;
    endtask

    task automatic drv1(input logic v, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        V1 = v; Wr1 = w; Ad1 = a; Dt1 = d;
    endtask

    task automatic test_reset;
        Rst0 = 1'b1; Rst1 = 1'b1;
        repeat (3) @(negedge Clk);
        total++; if (Rdy0 !== 1'b0) $display("FAIL rst_ready got %b want 0", Rdy0); else passed++;
        total++; if (RV0 !== 1'b0) $display("FAIL rst_rspvalid got %b want 0", RV0); else passed++;
        total++; if (RD0 !== 8'h00) $display("FAIL rst_rspdata got %h want 00", RD0); else passed++;
        total++; if (AE0 !== 1'b0) $display("FAIL rst_addrerr got %b want 0", AE0); else passed++;
        total++; if (By0 !== BUSY_RST) $display("FAIL rst_busy0 got %b want %b", By0, BUSY_RST); else passed++;
        total++; if (By1 !== BUSY_RST) $display("FAIL rst_busy1 got %b want %b", By1, BUSY_RST); else passed++;
    endtask

    task automatic test_ready_latency;
        int n0 = 0, n1 = 0, busy_bad = 0;
        Rst0 = 1'b0; Rst1 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge Clk);
            if (Rdy0 && n0 == 0) n0 = n;
            if (Rdy1 && n1 == 0) n1 = n;
            if (!Rdy0 && By0 !== BUSY_RST) busy_bad++;
            if (n0 != 0 && n1 != 0) break;
        end
        total++; if (n0 != LAT0) $display("FAIL latency0 got %0d want %0d", n0, LAT0); else passed++;
        total++; if (n1 != LAT1) $display("FAIL latency1 got %0d want %0d", n1, LAT1); else passed++;
        total++; if (busy_bad != 0) $display("FAIL busy_during_init got %0d bad want 0", busy_bad); else passed++;
        total++; if (By0 !== 1'b0) $display("FAIL busy_after_ready got %b want 0", By0); else passed++;
    endtask

`ifdef DATA_MEM_INIT_EN
    task automatic test_preload;
        logic [7:0] ad[6] = '{8'd0, 8'd1, 8'd2, 8'd15, 8'd3, 8'd255};
        logic [7:0] ex[6] = '{8'd7, 8'd2, 8'd3, 8'd15, 8'd0, 8'd0};
        for (int i = 0; i < 6; i++) begin
            drv0(1'b1, 1'b0, ad[i], 8'h00);
            drv0(1'b0, 1'b0, 8'h00, 8'h00);
            total++;
            if ({RV0, AE0, RD0} !== {1'b1, 1'b0, ex[i]})
                $display("FAIL preload[%0d] got v=%b e=%b d=%h want v=1 e=0 d=%h", ad[i], RV0, AE0, RD0, ex[i]);
            else passed++;
        end
        drv1(1'b1, 1'b0, 8'd15, 8'h00);
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        total++; if ({RV1, RD1} !== {1'b1, 8'd15}) $display("FAIL preload1_15 got v=%b d=%h want v=1 d=0f", RV1, RD1); else passed++;
    endtask
`endif

    task automatic test_raw;
        drv0(1'b1, 1'b1, 8'h10, 8'hA5);
        drv0(1'b1, 1'b0, 8'h10, 8'h00);
        total++; if (RV0 !== 1'b0) $display("FAIL raw_write_rsp got %b want 0", RV0); else passed++;
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        total++; if ({RV0, RD0} !== {1'b1, 8'hA5}) $display("FAIL raw_read got v=%b d=%h want v=1 d=a5", RV0, RD0); else passed++;
        @(negedge Clk);
        total++; if ({RV0, RD0} !== {1'b0, 8'hA5}) $display("FAIL raw_hold got v=%b d=%h want v=0 d=a5", RV0, RD0); else passed++;
        drv0(1'b1, 1'b1, 8'h05, 8'h3C);
        drv0(1'b1, 1'b0, 8'h05, 8'h00);
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        total++; if ({RV0, RD0} !== {1'b1, 8'h3C}) $display("FAIL rw_addr5 got v=%b d=%h want v=1 d=3c", RV0, RD0); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] ad[2][3] = '{'{8'h00, 8'h01, 8'h02}, '{8'h20, 8'h21, 8'h22}};
        logic [7:0] ex[2][3] = '{'{8'h07, 8'h02, 8'h03}, '{8'h11, 8'h22, 8'h33}};
        int s0 = INIT_EN ? 0 : 1;
        for (int i = 0; i < 3; i++) drv0(1'b1, 1'b1, ad[1][i], ex[1][i]);
        for (int s = s0; s < 2; s++) begin
            drv0(1'b1, 1'b0, ad[s][0], 8'h00);
            for (int i = 1; i <= 3; i++) begin
                drv0(i < 3, 1'b0, (i < 3) ? ad[s][i % 3] : 8'h00, 8'h00);
                total++;
                if ({RV0, RD0} !== {1'b1, ex[s][i-1]})
                    $display("FAIL b2b[%0d.%0d] got v=%b d=%h want v=1 d=%h", s, i - 1, RV0, RD0, ex[s][i-1]);
                else passed++;
            end
            @(negedge Clk);
            total++; if (RV0 !== 1'b0) $display("FAIL b2b_end[%0d] got %b want 0", s, RV0); else passed++;
        end
    endtask

    task automatic test_oor;
        drv1(1'b1, 1'b1, 8'hC7, 8'h77);
        drv1(1'b1, 1'b1, 8'hC8, 8'h5A);
        total++; if (AE1 !== 1'b0) $display("FAIL oor_inrange_wr got %b want 0", AE1); else passed++;
        drv1(1'b1, 1'b0, 8'hC8, 8'h00);
        total++; if ({RV1, AE1} !== 2'b01) $display("FAIL oor_wr got v=%b e=%b want v=0 e=1", RV1, AE1); else passed++;
        drv1(1'b1, 1'b0, 8'hC7, 8'h00);
        total++; if ({RV1, AE1, RD1} !== {2'b11, 8'h00}) $display("FAIL oor_rd got v=%b e=%b d=%h want v=1 e=1 d=00", RV1, AE1, RD1); else passed++;
        drv1(1'b0, 1'b0, 8'h00, 8'h00);
        total++; if ({RV1, AE1, RD1} !== {2'b10, 8'h77}) $display("FAIL oor_c7 got v=%b e=%b d=%h want v=1 e=0 d=77", RV1, AE1, RD1); else passed++;
        @(negedge Clk);
        total++; if ({RV1, AE1, RD1} !== {2'b00, 8'h77}) $display("FAIL oor_hold got v=%b e=%b d=%h want v=0 e=0 d=77", RV1, AE1, RD1); else passed++;
    endtask

    task automatic test_reset_mid;
        int n0 = 0;
        logic [7:0] exp10 = INIT_EN ? 8'h00 : 8'hA5;
        drv0(1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge Clk);
        #2 Rst0 = 1'b1;
        #1;
        total++; if ({RV0, RD0, Rdy0} !== {1'b0, 8'h00, 1'b0}) $display("FAIL mid_rst got v=%b d=%h r=%b want v=0 d=00 r=0", RV0, RD0, Rdy0); else passed++;
        @(negedge Clk);
        V0 = 1'b0; Rst0 = 1'b0;
        repeat (50) @(negedge Clk);
        total++; if ({By0, Rdy0} !== {BUSY_RST, !BUSY_RST}) $display("FAIL mid_idx50 got b=%b r=%b want b=%b r=%b", By0, Rdy0, BUSY_RST, !BUSY_RST); else passed++;
        Rst0 = 1'b1;
        @(negedge Clk);
        Rst0 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge Clk);
            if (Rdy0) begin
                n0 = n;
                break;
            end
        end
        total++; if (n0 != LAT0) $display("FAIL mid_latency got %0d want %0d", n0, LAT0); else passed++;
        drv0(1'b1, 1'b0, 8'h10, 8'h00);
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        total++; if ({RV0, RD0} !== {1'b1, exp10}) $display("FAIL mid_contents got v=%b d=%h want v=1 d=%h", RV0, RD0, exp10); else passed++;
    endtask

    initial begin
        V0 = 1'b0; Wr0 = 1'b0; Ad0 = '0; Dt0 = '0; Rst0 = 1'b1;
        V1 = 1'b0; Wr1 = 1'b0; Ad1 = '0; Dt1 = '0; Rst1 = 1'b1;
        test_reset();
        test_ready_latency();
`ifdef DATA_MEM_INIT_EN
        test_preload();
`endif
        test_raw();
        test_back_to_back();
        test_oor();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
